// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl -- command controller behind the UART receiver (clock25 domain).
//
// Parses fixed 5-byte frames  SYNC_BYTE, CMD, ADDR, DATA, CHK  (CHK = CMD^ADDR^DATA).
// CMD 8'h57 writes DATA to register ADDR; CMD 8'h52 reads register ADDR.
// Every frame is answered with one byte: ACK_BYTE for a write, the register
// value for a read, NAK_BYTE for a bad checksum or unknown command.
//
// Optional feature (macro UART_CMD_TIMEOUT_EN): an inter-byte timeout of
// TIMEOUT_CYCLES clocks while a frame is being received drops the frame,
// returns to SYNC and counts an error. Without the macro the parser waits
// indefinitely for the next byte.
//
// Ports:
//   clock25    in   25 MHz clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   ready      in   one-cycle strobe, rbyte valid
//   rbyte      in   [7:0] received byte
//   reg_we     out  one-cycle register write strobe
//   reg_addr   out  [7:0] register address (registered)
//   reg_wdata  out  [7:0] register write data (registered)
//   reg_rdata  in   [7:0] combinational readback of reg_addr
//   tx_send    out  one-cycle transmit request
//   tx_byte    out  [7:0] response byte, held until the transmitter is done
//   tx_busy    in   transmitter busy, rises the cycle after tx_send
//   err_cnt    out  [7:0] saturating error counter
module uart_cmd_ctrl #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter logic [7:0] ACK_BYTE       = 8'h06,
  parameter logic [7:0] NAK_BYTE       = 8'h15,
  parameter int         TIMEOUT_CYCLES = 25000
) (
  input  logic       clock25,
  input  logic       reset_n,
  input  logic       ready,
  input  logic [7:0] rbyte,
  output logic       reg_we,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       tx_send,
  output logic [7:0] tx_byte,
  input  logic       tx_busy,
  output logic [7:0] err_cnt
);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;

  // ST_TX_SKIP is the cycle right after tx_send, where tx_busy has not risen yet.
  typedef enum logic [3:0] {
    ST_SYNC, ST_CMD, ST_ADDR, ST_DATA, ST_CHK, ST_EXEC, ST_RESP, ST_TX_SKIP, ST_WAIT_TX
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_cmd;
  logic [7:0] r_xor;
  logic       r_chk_ok;
  logic       w_exec_ok;
  logic       w_is_write;
  logic       w_drop;
  logic       w_err_inc;
  logic       w_timeout;

  assign w_is_write = (r_cmd == CMD_WRITE);
  assign w_exec_ok  = r_chk_ok && (w_is_write || (r_cmd == CMD_READ));

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            w_parse;

  assign w_parse   = (r_state == ST_CMD) || (r_state == ST_ADDR) ||
                     (r_state == ST_DATA) || (r_state == ST_CHK);
  // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle inside a frame.
  assign w_timeout = w_parse && !ready && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock25 or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= '0;
    end else if (!w_parse || ready || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // State register
  always_ff @(posedge clock25 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_SYNC;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a mid-frame SYNC_BYTE is ordinary payload.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_SYNC:    if (ready && (rbyte == SYNC_BYTE)) w_next = ST_CMD;
      ST_CMD:     if (ready) w_next = ST_ADDR;
      ST_ADDR:    if (ready) w_next = ST_DATA;
      ST_DATA:    if (ready) w_next = ST_CHK;
      ST_CHK:     if (ready) w_next = ST_EXEC;
      ST_EXEC:    w_next = ST_RESP;
      ST_RESP:    if (!tx_busy) w_next = ST_TX_SKIP;
      ST_TX_SKIP: w_next = ST_WAIT_TX;
      ST_WAIT_TX: if (!tx_busy) w_next = ST_SYNC;
      default:    w_next = ST_SYNC;
    endcase
    if (w_timeout) w_next = ST_SYNC;
  end

  // Output logic
  always_comb begin
    reg_we    = 1'b0;
    tx_send   = 1'b0;
    w_drop    = 1'b0;
    w_err_inc = 1'b0;
    case (r_state)
      ST_EXEC:    begin
                    reg_we = w_exec_ok && w_is_write;
                    w_drop = ready;
                  end
      ST_RESP:    begin
                    tx_send = !tx_busy;
                    w_drop  = ready;
                  end
      ST_TX_SKIP,
      ST_WAIT_TX: w_drop = ready;
      default:    ;
    endcase
    // Several error sources in one cycle still add only one.
    w_err_inc = w_drop || w_timeout || ((r_state == ST_EXEC) && !w_exec_ok);
  end

  // Registered outputs
  always_ff @(posedge clock25 or negedge reset_n) begin
    if (!reset_n) begin
      reg_addr  <= '0;
      reg_wdata <= '0;
      tx_byte   <= '0;
      err_cnt   <= '0;
    end else begin
      if ((r_state == ST_ADDR) && ready) reg_addr  <= rbyte;
      if ((r_state == ST_DATA) && ready) reg_wdata <= rbyte;
      if (r_state == ST_EXEC) begin
        if (!w_exec_ok)     tx_byte <= NAK_BYTE;
        else if (w_is_write) tx_byte <= ACK_BYTE;
        else                tx_byte <= reg_rdata;
      end
      if (w_err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

  // Frame parsing scratch registers; only meaningful once a frame is underway.
  always_ff @(posedge clock25) begin
    if ((r_state == ST_CMD) && ready) begin
      r_cmd <= rbyte;
      r_xor <= rbyte;
    end
    if (((r_state == ST_ADDR) || (r_state == ST_DATA)) && ready) r_xor <= r_xor ^ rbyte;
    if ((r_state == ST_CHK) && ready) r_chk_ok <= (rbyte == r_xor);
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed frames from the test plan plus
// randomized frames, checked against a frame-level reference model.
module tb_uart_cmd_ctrl;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic       clock25 = 1'b0;
  logic       reset_n;
  logic       ready = 1'b0;
  logic [7:0] rbyte = 8'h00;
  logic       reg_we;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       tx_send;
  logic [7:0] tx_byte;
  logic       tx_busy;
  logic [7:0] err_cnt;
  logic       busy_resp = 1'b0;
  logic       busy_hold = 1'b0;
  int         busy_len  = 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Register file attached to the register port
  logic [7:0]  mem [256];
  // Observed events
  logic [7:0]  tx_q [$];
  logic [15:0] we_q [$];
  // Reference model
  logic [7:0]  m_mem [256];
  int          m_err = 0;

  assign tx_busy   = busy_resp | busy_hold;
  assign reg_rdata = mem[reg_addr];

  uart_cmd_ctrl dut (
    .clock25   (clock25),
    .reset_n   (reset_n),
    .ready     (ready),
    .rbyte     (rbyte),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .tx_send   (tx_send),
    .tx_byte   (tx_byte),
    .tx_busy   (tx_busy),
    .err_cnt   (err_cnt)
  );

  always #20 clock25 = ~clock25;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Register file and event monitor
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    forever begin
      @(negedge clock25);
      if (reg_we) begin
        we_q.push_back({reg_addr, reg_wdata});
        mem[reg_addr] = reg_wdata;
      end
      if (tx_send) tx_q.push_back(tx_byte);
    end
  end

  // Transmitter: busy from the cycle after tx_send for busy_len cycles
  initial begin
    forever begin
      @(negedge clock25);
      if (tx_send) begin
        @(posedge clock25);
        #1 busy_resp = 1'b1;
        repeat (busy_len) @(posedge clock25);
        #1 busy_resp = 1'b0;
      end
    end
  end

  initial begin
    #3_600_000;
    $display("FAIL watchdog: simulation did not finish, got 0, expected 1");
    $fatal(1, "watchdog");
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock25);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    ready = 1'b1;
    rbyte = b;
    step(1);
    ready = 1'b0;
    rbyte = 8'($urandom);
  endtask

  task automatic wait_idle();
    bit got = 0;
    step(1);
    for (int k = 0; k < 1000; k++) begin
      @(negedge clock25);
      if (!tx_busy) begin
        got = 1;
        break;
      end
    end
    check("idle_bound", got, 1);
    step(1);
  endtask

  // Reference: expected response byte for a complete frame, updating model state.
  task automatic model_frame(input logic [39:0] fr, output logic [7:0] exp_tx,
                             output int exp_we);
    logic [7:0] c, a, d, k;
    bit ok;
    c = fr[31:24];
    a = fr[23:16];
    d = fr[15:8];
    k = fr[7:0];
    ok = (k == (c ^ a ^ d)) && ((c == 8'h57) || (c == 8'h52));
    exp_we = 0;
    if (!ok) begin
      exp_tx = NAK;
      if (m_err < 255) m_err++;
    end else if (c == 8'h57) begin
      exp_tx   = ACK;
      m_mem[a] = d;
      exp_we   = 1;
    end else begin
      exp_tx = m_mem[a];
    end
  endtask

  task automatic run_frame(input logic [39:0] fr, input int idle_mid);
    logic [7:0] exp_tx;
    int exp_we;
    int lat = 0;
    bit got = 0;
    model_frame(fr, exp_tx, exp_we);
    tx_q.delete();
    we_q.delete();
    for (int i = 0; i < 5; i++) begin
      send_byte(fr[39-8*i -: 8]);
      if (i == 1) step(idle_mid);
      if (i < 4) step($urandom_range(0, 2));
    end
    for (int k = 0; k < 1000; k++) begin
      @(negedge clock25);
      lat++;
      if (tx_send) begin
        got = 1;
        break;
      end
    end
    check("resp_seen", got, 1);
    if (got) begin
      check("latency", lat, 2);
      check("tx_byte", tx_byte, exp_tx);
      wait_idle();
    end else begin
      step(1);
    end
    check("tx_pulses", tx_q.size(), 1);
    check("we_count", we_q.size(), exp_we);
    if (exp_we == 1 && we_q.size() == 1) check("we_addr_data", we_q[0], fr[23:8]);
    check("err_cnt", err_cnt, m_err);
  endtask

  function automatic logic [39:0] mk(input logic [7:0] c, input logic [7:0] a,
                                     input logic [7:0] d);
    return {8'hA5, c, a, d, c ^ a ^ d};
  endfunction

  initial begin
    logic [7:0] c, a, d, k;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    reset_n = 1'b1;
    #5 reset_n = 1'b0;
    repeat (3) @(posedge clock25);
    @(negedge clock25);
    check("rst_reg_we", reg_we, 0);
    check("rst_tx_send", tx_send, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_err_cnt", err_cnt, 0);
    @(posedge clock25);
    #1 reset_n = 1'b1;
    step(2);

    // Junk before a frame is ignored silently
    send_byte(8'h00);
    send_byte(8'hFF);
    step(1);
    send_byte(8'h12);
    run_frame(40'hA5_57_10_3C_7B, 0);
    check("junk_err", err_cnt, 0);
    run_frame(40'hA5_52_10_00_42, 0);
    // SYNC_BYTE as payload
    run_frame(40'hA5_57_A5_A5_57, 0);
    run_frame(40'hA5_52_A5_00_F7, 0);
    // Bad checksum, unknown command
    run_frame(40'hA5_57_10_3C_00, 0);
    check("bad_chk_err", err_cnt, 1);
    run_frame(40'hA5_41_00_00_41, 0);

    // Transmitter busy for 200 cycles while a response is pending
    busy_hold = 1'b1;
    tx_q.delete();
    we_q.delete();
    for (int i = 0; i < 5; i++) send_byte(mk(8'h57, 8'h20, 8'h5A) >> (32 - 8*i));
    m_mem[8'h20] = 8'h5A;
    for (int k2 = 0; k2 < 200; k2++) begin
      if (k2 == 100) send_byte(8'($urandom));
      else step(1);
    end
    if (m_err < 255) m_err++;
    check("held_no_send", tx_q.size(), 0);
    check("held_err", err_cnt, m_err);
    busy_hold = 1'b0;
    @(negedge clock25);
    check("send_after_release", tx_send, 1);
    check("held_tx_byte", tx_byte, ACK);
    wait_idle();
    check("held_pulses", tx_q.size(), 1);
    check("held_we", we_q.size(), 1);

    // Randomized frames
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0, 1: c = 8'h57;
        2:    c = 8'h52;
        default: begin
          c = 8'($urandom);
          if (c == 8'h57 || c == 8'h52) c = 8'h00;
        end
      endcase
      a = 8'($urandom_range(8'h30, 8'h37));
      d = 8'($urandom);
      k = c ^ a ^ d;
      if ($urandom_range(0, 3) == 0) k = k ^ 8'($urandom_range(1, 255));
      busy_len = $urandom_range(1, 6);
      run_frame({8'hA5, c, a, d, k}, 0);
    end
    busy_len = 1;

    // Long pause after CMD
`ifdef UART_CMD_TIMEOUT_EN
    tx_q.delete();
    we_q.delete();
    send_byte(8'hA5);
    send_byte(8'h57);
    step(25100);
    send_byte(8'h10);
    send_byte(8'h3C);
    send_byte(8'h7B);
    if (m_err < 255) m_err++;
    step(50);
    check("to_no_send", tx_q.size(), 0);
    check("to_no_we", we_q.size(), 0);
    check("to_err", err_cnt, m_err);
`else
    run_frame(40'hA5_57_11_3D_7B, 25100);
`endif

    // Error counter saturation
    for (int n = 0; n < 256; n++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      run_frame({8'hA5, 8'h57, a, d, 8'h57 ^ a ^ d ^ 8'h01}, 0);
    end
    check("err_saturated", err_cnt, 8'hFF);

    // Reset in the middle of a frame
    tx_q.delete();
    we_q.delete();
    send_byte(8'hA5);
    send_byte(8'h57);
    reset_n = 1'b0;
    @(negedge clock25);
    check("midrst_err", err_cnt, 0);
    step(1);
    reset_n = 1'b1;
    m_err = 0;
    step(50);
    check("midrst_no_send", tx_q.size(), 0);
    check("midrst_no_we", we_q.size(), 0);
    check("midrst_addr", reg_addr, 0);
    run_frame(40'hA5_57_10_3C_7B, 0);
    run_frame(40'hA5_52_10_00_42, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
